fp_mul_result_buffer: RTL and testbench
=======================================

// Module: fp_mul_result_buffer
// PURPOSE
//  Downstream capture stage for the combinational single-precision multiplier.
//  Registers each result word with its Exception/Overflow/Underflow flags into a DEPTH-entry FIFO.
//  Presents entries to the consumer over a valid/ready interface.
//  Keeps sticky exception status and a saturating count of flagged results for software readout.
// PARAMETERS
//  DEPTH   4  FIFO entries; power of two, >= 2
//  CNT_W   8  width of flagged-result counter
// PORTS
//  clk            in   1      single clock, rising edge
//  rst_n          in   1      asynchronous active-low reset
//  in_valid       in   1      multiplier result valid this cycle
//  in_ready       out  1      buffer can accept (= not full)
//  in_result      in   32     multiplier result word (IEEE-754 single)
//  in_exception   in   1      multiplier Exception flag
//  in_overflow    in   1      multiplier Overflow flag
//  in_underflow   in   1      multiplier Underflow flag
//  out_valid      out  1      head entry valid
//  out_ready      in   1      consumer accepts head entry
//  out_result     out  32     head result word
//  out_flags      out  3      head flags {exception, overflow, underflow}
//  level          out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
//  sticky_flags   out  3      OR of flags of all accepted entries since reset/clear
//  clear_sticky   in   1      one-cycle pulse: clear sticky_flags and flag_count
//  flag_count     out  CNT_W  number of accepted entries with any flag set, saturating
// BEHAVIOUR
//  Reset (rst_n=0, async): all outputs are 0 except in_ready=1.
//   - Pointers, level, sticky_flags and flag_count = 0; out_result/out_flags = 0.
//   - Entries in flight are discarded; an entry offered during reset is not accepted.
//  Push: in_valid & in_ready at a rising edge writes {flags,result} at the write pointer.
//  Pop: out_valid & out_ready at a rising edge retires the head entry.
//  Data path:
//   - First-word-fall-through: out_result/out_flags drive the head entry combinationally from storage.
//   - Contents are don't-care when out_valid=0, but are held at 0 after reset.
//   - Latency: an entry pushed at edge N is visible with out_valid=1 after edge N.
//  Full and empty:
//   - in_ready = (level != DEPTH). No bypass: when full, a push is refused even if a pop occurs in the same cycle.
//   - Empty: out_valid=0, and out_ready is ignored.
//  Simultaneous events:
//   - Push and pop together (level in 1..DEPTH-1): level unchanged, both pointers advance.
//   - Pointers are log2(DEPTH) bits and wrap modulo DEPTH.
//  Upstream must hold in_result and the flags stable while in_valid=1 & in_ready=0.
//  Input values are stored bit-exact; no arithmetic is done on result words.
//  Status (updated on accepted pushes only):
//   - sticky_flags |= pushed flags.
//   - flag_count += 1 if any pushed flag is 1; saturates at 2^CNT_W-1.
//   - clear_sticky alone: sticky_flags <= 0 and flag_count <= 0 at the next edge.
//   - clear_sticky with a flagged push in the same cycle: clear is applied first.
//     Result: sticky_flags = new flags, flag_count = 1.
//  Flags are stored exactly as received; combinations such as E=1,O=1 are not reinterpreted.
// TESTING
//  1 Single pass-through: push 0x4532_10EA, flags 000, out_ready=1.
//    -> out_valid next cycle with 0x4532_10EA, flags 000; level returns to 0; sticky stays 000.
//  2 Fill/stall: out_ready=0, push 0x4235_5063, 0xC235_5063, 0x441E_5374, 0x4B80_0000.
//    -> level=4, in_ready=0; fifth push refused.
//    -> Drain yields the four words in order; in_ready=1 after the first pop.
//  3 Flags and sticky: push 0x0000_0000 flags 110 (inf*inf), then 0x0000_0000 flags 001.
//    -> out_flags 110 then 001; sticky_flags=111; flag_count=2.
//  4 Concurrent push/pop at level 2 for 8 cycles with an incrementing pattern.
//    -> level stays 2; output order exact across pointer wrap.
//  5 clear_sticky with a flagged push (flags 100) in the same cycle.
//    -> sticky_flags=100, flag_count=1.
//  6 Saturation and reset: CNT_W=2, five flagged pushes.
//    -> flag_count=3, no wrap to 0.
//    -> Assert rst_n low mid-stream at level 3: level=0, out_valid=0, sticky=0 immediately, without waiting for a clock.

Source files
------------

// File: rtl/fp_mul_result_buffer.sv
// Capture FIFO for single-precision multiplier results with their E/O/U flags.
// First-word-fall-through read side, sticky flag status and saturating flagged-result count.
module fp_mul_result_buffer #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              in_result,
  input  logic                     in_exception,
  input  logic                     in_overflow,
  input  logic                     in_underflow,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_result,
  output logic [2:0]               out_flags,
  output logic [$clog2(DEPTH):0]   level,
  output logic [2:0]               sticky_flags,
  input  logic                     clear_sticky,
  output logic [CNT_W-1:0]         flag_count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;

  logic [34:0]       r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [LVL_W-1:0]  r_level;
  logic [2:0]        r_sticky;
  logic [CNT_W-1:0]  r_count;

  logic              w_push;
  logic              w_pop;
  logic [2:0]        w_in_flags;
  logic              w_any_flag;
  logic              w_cnt_max;

  assign w_in_flags = {in_exception, in_overflow, in_underflow};
  assign w_any_flag = |w_in_flags;
  assign w_cnt_max  = (r_count == '1);

  // in_ready depends only on level, so a pop never frees a slot for a push in the same cycle.
  assign in_ready  = (r_level != LVL_W'(DEPTH));
  assign out_valid = (r_level != '0);
  assign w_push    = in_valid & in_ready;
  assign w_pop     = out_valid & out_ready;

  assign {out_flags, out_result} = r_mem[r_rd_ptr];
  assign level        = r_level;
  assign sticky_flags = r_sticky;
  assign flag_count   = r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= {w_in_flags, in_result};
        r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LVL_W'(1);
        2'b01:   r_level <= r_level - LVL_W'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  // A clear coinciding with a push is applied first, so the push's flags survive it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sticky <= '0;
      r_count  <= '0;
    end else if (clear_sticky) begin
      r_sticky <= w_push ? w_in_flags : 3'b000;
      r_count  <= (w_push && w_any_flag) ? CNT_W'(1) : '0;
    end else if (w_push) begin
      r_sticky <= r_sticky | w_in_flags;
      if (w_any_flag && !w_cnt_max) begin
        r_count <= r_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_fp_mul_result_buffer.sv
// Directed bench for fp_mul_result_buffer: default instance plus a CNT_W=2 instance
// for counter saturation; both share clock and reset.
module tb_fp_mul_result_buffer;

  logic        clk;
  logic        rst_n;

  logic        in_valid, in_ready, in_exception, in_overflow, in_underflow;
  logic [31:0] in_result;
  logic        out_valid, out_ready, clear_sticky;
  logic [31:0] out_result;
  logic [2:0]  out_flags, sticky_flags;
  logic [2:0]  level;
  logic [7:0]  flag_count;

  logic        b_in_valid, b_in_ready, b_in_exception, b_in_overflow, b_in_underflow;
  logic [31:0] b_in_result;
  logic        b_out_valid, b_out_ready, b_clear_sticky;
  logic [31:0] b_out_result;
  logic [2:0]  b_out_flags, b_sticky_flags;
  logic [2:0]  b_level;
  logic [1:0]  b_flag_count;

  int total = 0;
  int fails = 0;

  fp_mul_result_buffer #(.DEPTH(4), .CNT_W(8)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_result(in_result),
    .in_exception(in_exception), .in_overflow(in_overflow), .in_underflow(in_underflow),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_flags(out_flags), .level(level), .sticky_flags(sticky_flags),
    .clear_sticky(clear_sticky), .flag_count(flag_count)
  );

  fp_mul_result_buffer #(.DEPTH(4), .CNT_W(2)) u_sat (
    .clk(clk), .rst_n(rst_n),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_result(b_in_result),
    .in_exception(b_in_exception), .in_overflow(b_in_overflow), .in_underflow(b_in_underflow),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_result(b_out_result),
    .out_flags(b_out_flags), .level(b_level), .sticky_flags(b_sticky_flags),
    .clear_sticky(b_clear_sticky), .flag_count(b_flag_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] d, input logic [2:0] f);
    in_valid = v;
    in_result = d;
    {in_exception, in_overflow, in_underflow} = f;
  endtask

  task automatic drive_b(input logic v, input logic [31:0] d, input logic [2:0] f);
    b_in_valid = v;
    b_in_result = d;
    {b_in_exception, b_in_overflow, b_in_underflow} = f;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1'b1, 32'h1234_5678, 3'b111);
    out_ready = 1'b0;
    clear_sticky = 1'b0;
    drive_b(1'b0, '0, 3'b000);
    b_out_ready = 1'b0;
    b_clear_sticky = 1'b0;

    // Reset state, with an entry offered across a clock edge during reset
    tick();
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_level", level, 0);
    check("rst_out_result", out_result, 0);
    check("rst_out_flags", out_flags, 0);
    check("rst_sticky", sticky_flags, 0);
    check("rst_count", flag_count, 0);
    drive(1'b0, '0, 3'b000);
    @(negedge clk);
    rst_n = 1'b1;

    // 1: single pass-through
    drive(1'b1, 32'h4532_10EA, 3'b000);
    out_ready = 1'b1;
    tick();
    check("t1_valid", out_valid, 1);
    check("t1_result", out_result, 32'h4532_10EA);
    check("t1_flags", out_flags, 3'b000);
    check("t1_level", level, 1);
    drive(1'b0, '0, 3'b000);
    tick();
    check("t1_level0", level, 0);
    check("t1_empty", out_valid, 0);
    check("t1_sticky", sticky_flags, 0);

    // 2: fill and stall
    out_ready = 1'b0;
    drive(1'b1, 32'h4235_5063, 3'b000); tick();
    drive(1'b1, 32'hC235_5063, 3'b000); tick();
    drive(1'b1, 32'h441E_5374, 3'b000); tick();
    drive(1'b1, 32'h4B80_0000, 3'b000); tick();
    check("t2_level_full", level, 4);
    check("t2_in_ready_full", in_ready, 0);
    drive(1'b1, 32'hDEAD_BEEF, 3'b000); tick();
    check("t2_refused_level", level, 4);
    check("t2_head0", out_result, 32'h4235_5063);
    out_ready = 1'b1;
    tick();
    check("t2_nobypass_level", level, 3);
    check("t2_ready_after_pop", in_ready, 1);
    check("t2_head1", out_result, 32'hC235_5063);
    drive(1'b0, '0, 3'b000);
    tick();
    check("t2_head2", out_result, 32'h441E_5374);
    tick();
    check("t2_head3", out_result, 32'h4B80_0000);
    tick();
    check("t2_drained", out_valid, 0);
    check("t2_level0", level, 0);

    // 3: flags and sticky status
    out_ready = 1'b0;
    drive(1'b1, 32'h0000_0000, 3'b110); tick();
    drive(1'b1, 32'h0000_0000, 3'b001); tick();
    drive(1'b0, '0, 3'b000);
    check("t3_flags0", out_flags, 3'b110);
    check("t3_sticky", sticky_flags, 3'b111);
    check("t3_count", flag_count, 2);
    out_ready = 1'b1;
    tick();
    check("t3_flags1", out_flags, 3'b001);
    tick();
    check("t3_empty", out_valid, 0);

    // 4: concurrent push/pop at level 2 across pointer wrap
    out_ready = 1'b0;
    drive(1'b1, 32'h100, 3'b000); tick();
    drive(1'b1, 32'h101, 3'b000); tick();
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check("t4_head_pre", out_result, 32'h100 + i);
      drive(1'b1, 32'h102 + i, 3'b000);
      tick();
      check("t4_level", level, 2);
    end
    drive(1'b0, '0, 3'b000);
    check("t4_head_a", out_result, 32'h108);
    tick();
    check("t4_head_b", out_result, 32'h109);
    tick();
    check("t4_empty", out_valid, 0);
    check("t4_count", flag_count, 2);

    // 5: clear with a flagged push in the same cycle, then clear alone
    out_ready = 1'b0;
    clear_sticky = 1'b1;
    drive(1'b1, 32'h7F80_0000, 3'b100);
    tick();
    check("t5_sticky", sticky_flags, 3'b100);
    check("t5_count", flag_count, 1);
    drive(1'b0, '0, 3'b000);
    tick();
    check("t5_clr_sticky", sticky_flags, 0);
    check("t5_clr_count", flag_count, 0);
    clear_sticky = 1'b0;
    out_ready = 1'b1;
    tick();
    check("t5_empty", out_valid, 0);

    // 6: saturation on the CNT_W=2 instance, then async reset at level 3
    b_out_ready = 1'b1;
    drive_b(1'b1, 32'hA, 3'b100); tick();
    drive_b(1'b1, 32'hB, 3'b010); tick();
    drive_b(1'b1, 32'hC, 3'b001); tick();
    check("t6_count3", b_flag_count, 3);
    drive_b(1'b1, 32'hD, 3'b100); tick();
    drive_b(1'b1, 32'hE, 3'b011); tick();
    check("t6_count_sat", b_flag_count, 3);
    check("t6_sticky", b_sticky_flags, 3'b111);
    b_out_ready = 1'b0;
    drive_b(1'b1, 32'hF, 3'b000); tick();
    drive_b(1'b1, 32'h10, 3'b000); tick();
    drive_b(1'b0, '0, 3'b000);
    check("t6_level3", b_level, 3);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_rst_level", b_level, 0);
    check("t6_rst_valid", b_out_valid, 0);
    check("t6_rst_sticky", b_sticky_flags, 0);
    check("t6_rst_count", b_flag_count, 0);
    check("t6_rst_ready", b_in_ready, 1);
    check("t6_rst_result", b_out_result, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule
